// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with valid tracking, stall/flush handling,
// branch squash and a two-state interrupt-acceptance FSM. An accepted
// interrupt replaces one valid EX instruction with a bubble and records
// that instruction's PC in epc.
module ex_mem_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          validEX,
  input  logic [DW-1:0] pcEXin,
  input  logic [DW-1:0] branchaddrEX,
  input  logic [DW-1:0] aluresultEX,
  input  logic [DW-1:0] rtdataEX,
  input  logic [RW-1:0] writeregEX,
  input  logic          ALUequalEX,
  input  logic          MemWriteEX,
  input  logic          MemReadEX,
  input  logic          BranchEX,
  input  logic          RegWriteEX,
  input  logic          MemtoRegEX,
  input  logic          stall,
  input  logic          flush,
  input  logic          intterupt,
  input  logic          PCSrcMEM,
  output logic          validMEM,
  output logic [DW-1:0] branchaddrMEM,
  output logic [DW-1:0] memaddrMEM,
  output logic [DW-1:0] memwritedataMEM,
  output logic [RW-1:0] writeregMEM,
  output logic          ALUequalMEM,
  output logic          MemWriteMEM,
  output logic          MemReadMEM,
  output logic          BranchMEM,
  output logic          RegWriteMEM,
  output logic          MemtoRegMEM,
  output logic          irq_take,
  output logic [DW-1:0] epc
);

  localparam int NCTRL = 6;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } irqState_t;

  irqState_t        stateReg;
  irqState_t        stateNext;
  logic             intteruptQ;
  logic             irqEdge;
  logic             normalCycle;
  logic             takeIrq;
  logic             loadBubble;
  logic [NCTRL-1:0] ctrlEX;
  logic [NCTRL-1:0] ctrlReg;

  // Control bits travel as one vector so they can share the gating logic.
  assign ctrlEX = {ALUequalEX, MemWriteEX, MemReadEX, BranchEX, RegWriteEX, MemtoRegEX};

  assign irqEdge     = intterupt & ~intteruptQ;
  // A normal load is the only kind of cycle in which an interrupt may be taken.
  assign normalCycle = ~flush & ~PCSrcMEM & ~stall;
  assign takeIrq     = (stateReg == PEND) & normalCycle & validEX;
  // flush, branch squash and interrupt take all turn the MEM slot into a bubble.
  assign loadBubble  = flush | PCSrcMEM | takeIrq;

  // Previous interrupt level, sampled every cycle for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) intteruptQ <= 1'b0;
    else        intteruptQ <= intterupt;
  end

  // Interrupt FSM next state: edges arriving while pending (or on the take) are dropped.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (irqEdge) stateNext = PEND;
      PEND:    if (takeIrq) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Interrupt FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  // Registered take pulse lines up with the bubble in MEM; epc holds until the next take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_take <= 1'b0;
      epc      <= '0;
    end else begin
      irq_take <= takeIrq;
      if (takeIrq) epc <= pcEXin;
    end
  end

  // Datapath fields and valid bit: bubble beats stall, stall beats load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validMEM        <= 1'b0;
      branchaddrMEM   <= '0;
      memaddrMEM      <= '0;
      memwritedataMEM <= '0;
      writeregMEM     <= '0;
    end else if (loadBubble) begin
      validMEM        <= 1'b0;
      branchaddrMEM   <= '0;
      memaddrMEM      <= '0;
      memwritedataMEM <= '0;
      writeregMEM     <= '0;
    end else if (!stall) begin
      validMEM        <= validEX;
      branchaddrMEM   <= branchaddrEX;
      memaddrMEM      <= aluresultEX;
      memwritedataMEM <= rtdataEX;
      writeregMEM     <= writeregEX;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCTRL; gi++) begin : g_ctrl
      logic bitReg;

      // One control bit: cleared by a bubble, qualified by validEX on load.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)          bitReg <= 1'b0;
        else if (loadBubble) bitReg <= 1'b0;
        else if (!stall)     bitReg <= ctrlEX[gi] & validEX;
      end

      assign ctrlReg[gi] = bitReg;
    end
  endgenerate

  assign {ALUequalMEM, MemWriteMEM, MemReadMEM, BranchMEM, RegWriteMEM, MemtoRegMEM} = ctrlReg;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: a directed vector table, an asynchronous reset
// sequence and a randomized run checked against a behavioural model.
module tb_ex_mem_reg;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          validEX = 1'b0;
  logic [DW-1:0] pcEXin = '0;
  logic [DW-1:0] branchaddrEX = '0;
  logic [DW-1:0] aluresultEX = '0;
  logic [DW-1:0] rtdataEX = '0;
  logic [RW-1:0] writeregEX = '0;
  logic          ALUequalEX = 1'b0, MemWriteEX = 1'b0, MemReadEX = 1'b0;
  logic          BranchEX = 1'b0, RegWriteEX = 1'b0, MemtoRegEX = 1'b0;
  logic          stall = 1'b0, flush = 1'b0, intterupt = 1'b0, PCSrcMEM = 1'b0;
  logic          validMEM;
  logic [DW-1:0] branchaddrMEM, memaddrMEM, memwritedataMEM;
  logic [RW-1:0] writeregMEM;
  logic          ALUequalMEM, MemWriteMEM, MemReadMEM, BranchMEM, RegWriteMEM, MemtoRegMEM;
  logic          irq_take;
  logic [DW-1:0] epc;

  ex_mem_reg #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .validEX(validEX), .pcEXin(pcEXin),
    .branchaddrEX(branchaddrEX), .aluresultEX(aluresultEX), .rtdataEX(rtdataEX),
    .writeregEX(writeregEX), .ALUequalEX(ALUequalEX), .MemWriteEX(MemWriteEX),
    .MemReadEX(MemReadEX), .BranchEX(BranchEX), .RegWriteEX(RegWriteEX),
    .MemtoRegEX(MemtoRegEX), .stall(stall), .flush(flush), .intterupt(intterupt),
    .PCSrcMEM(PCSrcMEM), .validMEM(validMEM), .branchaddrMEM(branchaddrMEM),
    .memaddrMEM(memaddrMEM), .memwritedataMEM(memwritedataMEM),
    .writeregMEM(writeregMEM), .ALUequalMEM(ALUequalMEM), .MemWriteMEM(MemWriteMEM),
    .MemReadMEM(MemReadMEM), .BranchMEM(BranchMEM), .RegWriteMEM(RegWriteMEM),
    .MemtoRegMEM(MemtoRegMEM), .irq_take(irq_take), .epc(epc)
  );

  always #5 clk = ~clk;

  // Expected MEM-side view of the register.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] ba;
    logic [DW-1:0] ma;
    logic [DW-1:0] wd;
    logic [RW-1:0] wr;
    logic [5:0]    ctrl;
    logic          tk;
    logic [DW-1:0] epc;
  } outs_t;

  // Directed vector: cw={MemWrite,RegWrite}, flg={stall,flush,PCSrc,irq},
  // ef={validMEM,MemWriteMEM,RegWriteMEM,irq_take}.
  typedef struct {
    logic          v;
    logic [DW-1:0] pc;
    logic [DW-1:0] alu;
    logic [DW-1:0] rt;
    logic [1:0]    cw;
    logic [3:0]    flg;
    logic [3:0]    ef;
    logic [DW-1:0] ea;
    logic [DW-1:0] ed;
    logic [DW-1:0] eepc;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  outs_t mExp;
  bit    mPend;
  bit    mIrqPrev;
  vec_t  tbl [0:20];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mExp     = '0;
    mPend    = 1'b0;
    mIrqPrev = 1'b0;
  endtask

  // Behavioural rules: one pending request at most, taken on the first clean
  // valid cycle; bubble on flush/squash/take; hold on stall; else load.
  task automatic modelStep();
    bit rise, clean, take;
    rise     = intterupt && !mIrqPrev;
    mIrqPrev = intterupt;
    clean    = !flush && !PCSrcMEM && !stall;
    take     = mPend && clean && validEX;
    mExp.tk  = take;
    if (take) mExp.epc = pcEXin;
    if (flush || PCSrcMEM || take) begin
      mExp.v = 1'b0; mExp.ba = '0; mExp.ma = '0; mExp.wd = '0; mExp.wr = '0; mExp.ctrl = '0;
    end else if (!stall) begin
      mExp.v    = validEX;
      mExp.ba   = branchaddrEX;
      mExp.ma   = aluresultEX;
      mExp.wd   = rtdataEX;
      mExp.wr   = writeregEX;
      mExp.ctrl = validEX ? {ALUequalEX, MemWriteEX, MemReadEX, BranchEX, RegWriteEX, MemtoRegEX} : 6'b0;
    end
    if (take) mPend = 1'b0;
    else if (rise) mPend = 1'b1;
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic compareAll(input string tag);
    chk({tag, "_valid"}, {31'b0, validMEM}, {31'b0, mExp.v});
    chk({tag, "_branchaddr"}, branchaddrMEM, mExp.ba);
    chk({tag, "_memaddr"}, memaddrMEM, mExp.ma);
    chk({tag, "_wdata"}, memwritedataMEM, mExp.wd);
    chk({tag, "_writereg"}, {27'b0, writeregMEM}, {27'b0, mExp.wr});
    chk({tag, "_ctrl"}, {26'b0, ALUequalMEM, MemWriteMEM, MemReadMEM, BranchMEM, RegWriteMEM, MemtoRegMEM},
        {26'b0, mExp.ctrl});
    chk({tag, "_irqtake"}, {31'b0, irq_take}, {31'b0, mExp.tk});
    chk({tag, "_epc"}, epc, mExp.epc);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_valid"}, {31'b0, validMEM}, 32'h0);
    chk({tag, "_branchaddr"}, branchaddrMEM, 32'h0);
    chk({tag, "_memaddr"}, memaddrMEM, 32'h0);
    chk({tag, "_wdata"}, memwritedataMEM, 32'h0);
    chk({tag, "_writereg"}, {27'b0, writeregMEM}, 32'h0);
    chk({tag, "_ctrl"}, {26'b0, ALUequalMEM, MemWriteMEM, MemReadMEM, BranchMEM, RegWriteMEM, MemtoRegMEM}, 32'h0);
    chk({tag, "_irqtake"}, {31'b0, irq_take}, 32'h0);
    chk({tag, "_epc"}, epc, 32'h0);
  endtask

  task automatic driveAll(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] ba,
                          input logic [DW-1:0] alu, input logic [DW-1:0] rt, input logic [RW-1:0] wr,
                          input logic [5:0] ctrl, input logic [3:0] flg);
    validEX = v; pcEXin = pc; branchaddrEX = ba; aluresultEX = alu; rtdataEX = rt; writeregEX = wr;
    {ALUequalEX, MemWriteEX, MemReadEX, BranchEX, RegWriteEX, MemtoRegEX} = ctrl;
    {stall, flush, PCSrcMEM, intterupt} = flg;
  endtask

  initial begin
    modelReset();
    tbl[0]  = '{1'b1, 32'h0,        32'h100,  32'hDEAD, 2'b10, 4'b0000, 4'b1100, 32'h100,  32'hDEAD, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,        32'h200,  32'hBEEF, 2'b11, 4'b0000, 4'b0000, 32'h200,  32'hBEEF, 32'h0};
    tbl[2]  = '{1'b1, 32'h4,        32'h300,  32'h11,   2'b01, 4'b0000, 4'b1010, 32'h300,  32'h11,   32'h0};
    tbl[3]  = '{1'b1, 32'h8,        32'h400,  32'h22,   2'b10, 4'b1000, 4'b1010, 32'h300,  32'h11,   32'h0};
    tbl[4]  = '{1'b1, 32'hC,        32'h500,  32'h23,   2'b11, 4'b1000, 4'b1010, 32'h300,  32'h11,   32'h0};
    tbl[5]  = '{1'b1, 32'h10,       32'h600,  32'h24,   2'b00, 4'b1000, 4'b1010, 32'h300,  32'h11,   32'h0};
    tbl[6]  = '{1'b1, 32'h14,       32'h700,  32'h25,   2'b11, 4'b1100, 4'b0000, 32'h0,    32'h0,    32'h0};
    tbl[7]  = '{1'b1, 32'h18,       32'h800,  32'h33,   2'b01, 4'b0000, 4'b1010, 32'h800,  32'h33,   32'h0};
    tbl[8]  = '{1'b1, 32'h1C,       32'h900,  32'h34,   2'b11, 4'b1010, 4'b0000, 32'h0,    32'h0,    32'h0};
    tbl[9]  = '{1'b1, 32'h20,       32'hA00,  32'h35,   2'b01, 4'b0010, 4'b0000, 32'h0,    32'h0,    32'h0};
    tbl[10] = '{1'b1, 32'h00400008, 32'hB00,  32'h36,   2'b01, 4'b1001, 4'b0000, 32'h0,    32'h0,    32'h0};
    tbl[11] = '{1'b1, 32'h0040000C, 32'hB80,  32'h36,   2'b01, 4'b1001, 4'b0000, 32'h0,    32'h0,    32'h0};
    tbl[12] = '{1'b1, 32'h00400010, 32'hC00,  32'h37,   2'b01, 4'b0001, 4'b0001, 32'h0,    32'h0,    32'h00400010};
    tbl[13] = '{1'b1, 32'h00400014, 32'hD00,  32'h38,   2'b01, 4'b0001, 4'b1010, 32'hD00,  32'h38,   32'h00400010};
    tbl[14] = '{1'b1, 32'h18,       32'hE00,  32'h39,   2'b01, 4'b0000, 4'b1010, 32'hE00,  32'h39,   32'h00400010};
    tbl[15] = '{1'b0, 32'h1C,       32'hF00,  32'h3A,   2'b01, 4'b0001, 4'b0000, 32'hF00,  32'h3A,   32'h00400010};
    tbl[16] = '{1'b0, 32'h20,       32'h1000, 32'h3B,   2'b01, 4'b0000, 4'b0000, 32'h1000, 32'h3B,   32'h00400010};
    tbl[17] = '{1'b0, 32'h24,       32'h1100, 32'h3C,   2'b01, 4'b0001, 4'b0000, 32'h1100, 32'h3C,   32'h00400010};
    tbl[18] = '{1'b1, 32'h00400020, 32'h1200, 32'h3D,   2'b01, 4'b0001, 4'b0001, 32'h0,    32'h0,    32'h00400020};
    tbl[19] = '{1'b1, 32'h28,       32'h1300, 32'h3E,   2'b01, 4'b0001, 4'b1010, 32'h1300, 32'h3E,   32'h00400020};
    tbl[20] = '{1'b1, 32'h2C,       32'h1400, 32'h3F,   2'b01, 4'b0000, 4'b1010, 32'h1400, 32'h3F,   32'h00400020};

    // Power-on reset state.
    @(posedge clk);
    #1;
    checkAllZero("por");
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 21; i++) begin
      driveAll(tbl[i].v, tbl[i].pc, tbl[i].pc, tbl[i].alu, tbl[i].rt, 5'd0,
               {1'b0, tbl[i].cw[1], 2'b00, tbl[i].cw[0], 1'b0}, tbl[i].flg);
      cycle();
      chk($sformatf("row%0d_valid", i), {31'b0, validMEM}, {31'b0, tbl[i].ef[3]});
      chk($sformatf("row%0d_memwrite", i), {31'b0, MemWriteMEM}, {31'b0, tbl[i].ef[2]});
      chk($sformatf("row%0d_regwrite", i), {31'b0, RegWriteMEM}, {31'b0, tbl[i].ef[1]});
      chk($sformatf("row%0d_irqtake", i), {31'b0, irq_take}, {31'b0, tbl[i].ef[0]});
      chk($sformatf("row%0d_memaddr", i), memaddrMEM, tbl[i].ea);
      chk($sformatf("row%0d_wdata", i), memwritedataMEM, tbl[i].ed);
      chk($sformatf("row%0d_epc", i), epc, tbl[i].eepc);
      $display("txn row%0d: validMEM=%0b memaddr=%h irq_take=%0b epc=%h", i, validMEM, memaddrMEM, irq_take, epc);
    end

    // Asynchronous reset mid-PEND: load nonzero state, arm a request, then reset between edges.
    driveAll(1'b1, 32'h00400100, 32'h1234, 32'h5678, 32'h9ABC, 5'd7, 6'b111111, 4'b0000);
    cycle();
    compareAll("prereset_load");
    driveAll(1'b1, 32'h00400104, 32'h1111, 32'h2222, 32'h3333, 5'd9, 6'b111111, 4'b1001);
    cycle();
    compareAll("prereset_pend");
    #2;
    driveAll(1'b1, 32'hFFFF0000, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd31, 6'b111111, 4'b1111);
    reset = 1'b0;
    #1;
    checkAllZero("asyncreset");
    $display("txn asyncreset: validMEM=%0b memaddr=%h epc=%h", validMEM, memaddrMEM, epc);
    driveAll(1'b1, 32'h00400200, 32'h10, 32'h20, 32'h30, 5'd1, 6'b010010, 4'b0000);
    reset = 1'b1;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      pcEXin = 32'h00400200 + 32'(i * 4);
      cycle();
      compareAll($sformatf("postreset%0d", i));
      chk($sformatf("postreset%0d_noirq", i), {31'b0, irq_take}, 32'h0);
      $display("txn postreset%0d: validMEM=%0b irq_take=%0b", i, validMEM, irq_take);
    end

    // Randomized run against the behavioural model.
    for (int i = 0; i < 300; i++) begin
      logic ir;
      ir = intterupt;
      if ($urandom_range(0, 3) == 0) ir = ~ir;
      driveAll($urandom_range(0, 4) != 0, $urandom(), $urandom(), $urandom(), $urandom(),
               5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
               {$urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, ir});
      cycle();
      compareAll($sformatf("rnd%0d", i));
      $display("txn rnd%0d: validMEM=%0b memaddr=%h irq_take=%0b epc=%h", i, validMEM, memaddrMEM, irq_take, epc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 5-stage MIPS pipeline. Sits directly upstream of the MEM stage and feeds its branch target, memory address, store data and control inputs.
- Adds per-instruction valid tracking, stall/hold and flush/bubble insertion.
- Squashes the wrong-path EX instruction when MEM resolves a taken branch.
- Contains a small interrupt-acceptance FSM that converts one valid instruction into a bubble and records its PC as EPC.

Parameters:
- DW, 32, datapath/address width
- RW, 5, register specifier width

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
- validEX  input  1  EX holds a real instruction
- pcEXin  input  DW  PC of EX instruction
- branchaddrEX  input  DW  computed branch target
- aluresultEX  input  DW  ALU result / memory address
- rtdataEX  input  DW  store data
- writeregEX  input  RW  destination register
- ALUequalEX, MemWriteEX, MemReadEX, BranchEX, RegWriteEX, MemtoRegEX  input  1 each  EX control bits
- stall  input  1  hold register contents
- flush  input  1  force bubble
- intterupt  input  1  external interrupt request, level, synchronous to clk
- PCSrcMEM  input  1  taken-branch feedback from MEM
- validMEM  output  1  MEM holds a real instruction
- branchaddrMEM, memaddrMEM, memwritedataMEM  output  DW  registered copies of branchaddrEX, aluresultEX, rtdataEX
- writeregMEM  output  RW
- ALUequalMEM, MemWriteMEM, MemReadMEM, BranchMEM, RegWriteMEM, MemtoRegMEM  output  1 each
- irq_take  output  1  one-cycle pulse: interrupt accepted
- epc  output  DW  PC of the instruction replaced by the interrupt bubble

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0, FSM=IDLE, intterupt edge register=0.
- Per-cycle priority, evaluated at the rising edge: flush > PCSrcMEM > stall > irq take > normal load.
- Bubble: validMEM=0, all six control outputs=0, data/address/writereg outputs=0.
- flush=1 or PCSrcMEM=1: load bubble. PCSrcMEM=1 squashes the wrong-path EX instruction; applies even when stall=1.
- stall=1 (with no flush and no PCSrcMEM): all outputs hold, including validMEM.
- Normal load: outputs take the EX values. Control outputs are ANDed with validEX. validMEM=validEX. Latency is 1 cycle.
- Interrupt edge detect: irq_edge = intterupt & ~intterupt_q. intterupt_q is updated every cycle.
- FSM state IDLE: on irq_edge, go to PEND.
- FSM state PEND: take when the cycle would be a normal load (no flush, no PCSrcMEM, no stall) and validEX=1. On take:
  - load a bubble;
  - epc <= pcEXin;
  - irq_take=1 in the following cycle only (registered pulse, aligned with the bubble in MEM);
  - FSM returns to IDLE.
- In PEND, flush, PCSrcMEM, stall or validEX=0 keep the FSM in PEND with no side effects.
- An irq_edge in PEND, or in the take cycle itself, is dropped. Requests are not queued.
- epc holds its value until the next take. irq_take is 0 at all other times.
- Asserting reset mid-PEND discards the pending request.

Test Plan:
- Reset: drive all inputs nonzero, pulse reset low asynchronously -> all outputs 0 immediately, before any clock edge; no irq_take after release.
- Normal flow: validEX=1, aluresultEX=0x100, rtdataEX=0xDEAD, MemWriteEX=1 -> next cycle memaddrMEM=0x100, memwritedataMEM=0xDEAD, MemWriteMEM=1, validMEM=1. Repeat with validEX=0 -> all controls 0.
- Stall/flush priority:
  - stall=1 for 3 cycles while EX changes -> outputs frozen;
  - stall=1 & flush=1 -> bubble;
  - stall=1 & PCSrcMEM=1 -> bubble.
- Branch squash: PCSrcMEM=1 with validEX=1, RegWriteEX=1 -> next cycle validMEM=0, RegWriteMEM=0.
- Interrupt accept:
  - intterupt rises while stall=1 for 2 cycles -> no take during the stall;
  - first unstalled valid cycle with pcEXin=0x0040_0010 -> bubble, epc=0x0040_0010, irq_take=1 for exactly one cycle;
  - a second edge while in PEND is ignored -> exactly one irq_take.
- Interrupt vs bubble: PEND with validEX=0 for 2 cycles, then validEX=1 -> take occurs on the valid cycle only.
